// File: rtl/cpu_trace_streamer.sv
// cpu_trace_streamer: on a trigger, freezes the MIPS core and streams one
// architectural-state snapshot frame (header, cycle count, PC, hazard counts,
// register file, low data memory) as 32-bit words on a valid/ready stream.
module cpu_trace_streamer #(
  parameter int NREG = 32,
  parameter int NMEM = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        trig_i,
  input  logic [31:0] pc_i,
  input  logic        stall_i,
  input  logic        flush_i,
  output logic        freeze_o,
  output logic [4:0]  rf_addr_o,
  input  logic [31:0] rf_data_i,
  output logic [31:0] dm_addr_o,
  input  logic [31:0] dm_data_i,
  output logic [31:0] tx_data_o,
  output logic        tx_valid_o,
  output logic        tx_last_o,
  input  logic        tx_ready_i,
  output logic        busy_o
);

  localparam int         FRAME     = 4 + NREG + NMEM;
  localparam logic [6:0] REG_BEGIN = 7'd4;
  localparam logic [6:0] MEM_BEGIN = 7'(4 + NREG);
  localparam logic [6:0] FRAME_LEN = 7'(FRAME);
  localparam logic [6:0] LAST_IDX  = 7'(FRAME - 1);

  typedef enum logic [1:0] {IDLE, SNAP, STREAM} state_t;

  state_t      state;
  logic [31:0] cyc_cnt;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;
  logic [15:0] seq;
  logic        drop;
  logic [31:0] snap_cyc;
  logic [31:0] snap_pc;
  logic [15:0] snap_stall;
  logic [15:0] snap_flush;
  logic [6:0]  idx;
  logic [6:0]  mem_rel;
  logic [31:0] next_word;
  logic        count_en;
  logic        load_en;
  logic        last_xfer;
  logic        in_reg;
  logic        in_mem;

  // idx always names the word that will be loaded next, so the read ports
  // already point at it during the cycle before the load edge.
  assign count_en  = start_i && !freeze_o;
  assign load_en   = (state == STREAM) && (!tx_valid_o || tx_ready_i);
  assign last_xfer = load_en && tx_valid_o && tx_last_o;
  assign in_reg    = (state == STREAM) && (idx >= REG_BEGIN) && (idx < MEM_BEGIN);
  assign in_mem    = (state == STREAM) && (idx >= MEM_BEGIN) && (idx < FRAME_LEN);
  assign mem_rel   = idx - MEM_BEGIN;
  assign rf_addr_o = in_reg ? 5'(idx - REG_BEGIN) : 5'd0;
  assign dm_addr_o = in_mem ? {23'd0, mem_rel, 2'b00} : 32'd0;

  // Select the payload for the next word from the snapshot or the read ports.
  always_comb begin
    next_word = dm_data_i;
    if (idx == 7'd1) begin
      next_word = snap_cyc;
    end else if (idx == 7'd2) begin
      next_word = snap_pc;
    end else if (idx == 7'd3) begin
      next_word = {snap_stall, snap_flush};
    end else if (idx < MEM_BEGIN) begin
      next_word = rf_data_i;
    end
  end

  // Performance counters run only while the core runs and is not frozen.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc_cnt   <= 32'd0;
      stall_cnt <= 16'd0;
      flush_cnt <= 16'd0;
    end else if (count_en) begin
      cyc_cnt <= cyc_cnt + 32'd1;
      if (stall_i && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
      if (flush_i && (flush_cnt != 16'hFFFF)) begin
        flush_cnt <= flush_cnt + 16'd1;
      end
    end
  end

  // Frame sequencer: capture on trigger, emit header, then stream words.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      freeze_o   <= 1'b0;
      busy_o     <= 1'b0;
      tx_valid_o <= 1'b0;
      tx_last_o  <= 1'b0;
      tx_data_o  <= 32'd0;
      idx        <= 7'd0;
      seq        <= 16'd0;
      drop       <= 1'b0;
      snap_cyc   <= 32'd0;
      snap_pc    <= 32'd0;
      snap_stall <= 16'd0;
      snap_flush <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (trig_i) begin
            snap_cyc   <= cyc_cnt;
            snap_pc    <= pc_i;
            snap_stall <= stall_cnt;
            snap_flush <= flush_cnt;
            freeze_o   <= 1'b1;
            busy_o     <= 1'b1;
            idx        <= 7'd0;
            state      <= SNAP;
          end
        end
        SNAP: begin
          tx_data_o  <= {8'hA5, 7'd0, drop, seq};
          tx_valid_o <= 1'b1;
          tx_last_o  <= 1'b0;
          idx        <= 7'd1;
          drop       <= trig_i;
          state      <= STREAM;
        end
        STREAM: begin
          if (trig_i) begin
            drop <= 1'b1;
          end
          if (last_xfer) begin
            tx_valid_o <= 1'b0;
            tx_last_o  <= 1'b0;
            freeze_o   <= 1'b0;
            busy_o     <= 1'b0;
            seq        <= seq + 16'd1;
            idx        <= 7'd0;
            state      <= IDLE;
          end else if (load_en) begin
            tx_data_o  <= next_word;
            tx_valid_o <= 1'b1;
            tx_last_o  <= (idx == LAST_IDX);
            idx        <= idx + 7'd1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/cpu_trace_streamer.md
# cpu_trace_streamer

Hardware trace source for the single-cycle/pipelined MIPS core. On a trigger it freezes the CPU and serializes an architectural-state snapshot as one frame of 32-bit words on a valid/ready stream: header, cycle count, PC, stall/flush counts, every register-file entry and the first data-memory words. It lets silicon or an FPGA build emit the same per-cycle state the simulation bench prints. It sits beside the CPU top and taps the PC, hazard-unit signals, a spare register-file read port and a spare data-memory read port.

## Interface
- NREG, 32: register-file entries dumped, 1..32.
- NMEM, 8: 32-bit data-memory words dumped from byte address 0x00 upward, 0..32.
- clk  in  1: single clock; all state changes on the rising edge.
- rst  in  1: asynchronous, active-low reset.
- start_i  in  1: CPU running; the counters advance only while it is high.
- trig_i  in  1: snapshot request, sampled each edge.
- pc_i  in  32: current PC.
- stall_i  in  1: hazard-unit stall for this cycle.
- flush_i  in  1: hazard-unit flush for this cycle.
- freeze_o  out  1: global CPU hold; high for the whole dump.
- rf_addr_o  out  5: register read address.
- rf_data_i  in  32: combinational read data for rf_addr_o, same cycle.
- dm_addr_o  out  32: word-aligned byte address, bits [1:0]=0.
- dm_data_i  in  32: combinational little-endian word at dm_addr_o.
- tx_data_o  out  32: stream data.
- tx_valid_o  out  1: stream valid.
- tx_last_o  out  1: high with the final word of the frame.
- tx_ready_i  in  1: sink ready; a word transfers on an edge where valid and ready are both high.
- busy_o  out  1: a frame is in progress.

## Operation
- **Counters (active when start_i=1 and freeze_o=0):**
  - cyc_cnt: 32-bit, wraps.
  - stall_cnt: 16-bit, saturates at 0xFFFF; +1 when stall_i=1.
  - flush_cnt: 16-bit, saturates at 0xFFFF; +1 when flush_i=1.
  - stall_i and flush_i high together increment both.
- **Frame layout:** F = 4+NREG+NMEM words (44 at defaults).
  - W0: header {8'hA5, 7'b0, drop, seq[15:0]}.
  - W1: cyc_cnt snapshot.
  - W2: pc_i snapshot.
  - W3: {stall_cnt, flush_cnt} snapshot.
  - W4..W(3+NREG): registers 0..NREG-1.
  - Remaining words: data-memory words at addresses 0, 4, … 4(NMEM-1).
- **FSM states:** IDLE, SNAP, STREAM.
  - IDLE: trig_i=1 captures pc_i and the three counters, then goes to SNAP.
  - SNAP: one cycle. Loads W0 into the output register and moves to STREAM.
  - STREAM: the output register reloads with the next word when tx_valid_o=0 or a transfer occurs. The transfer of the word flagged tx_last_o returns the FSM to IDLE.
- **Word index:** idx counts loaded words.
  - rf_addr_o = idx-4 during register words, else 0.
  - dm_addr_o = 4*(idx-4-NREG) during memory words, else 0.
  - Read data is sampled into tx_data_o on the load edge. freeze_o guarantees the source is stable.
- **seq:** 16-bit, +1 at frame completion, wraps 0xFFFF→0.
- **drop:** set when trig_i=1 in SNAP or STREAM (that trigger is otherwise ignored). Cleared when the header of the next frame is loaded; the flag is reported in that header.
- **Data stability:** tx_data_o and tx_last_o are held stable while tx_valid_o=1 and tx_ready_i=0.
- **Reset:** reset asserted mid-frame aborts the frame immediately. There is no partial-frame recovery.

## Timing
- **Reset values:** freeze_o=0, busy_o=0, tx_valid_o=0, tx_last_o=0, tx_data_o=0, rf_addr_o=0, dm_addr_o=0; cyc_cnt, stall_cnt, flush_cnt, seq and drop all 0; FSM in IDLE.
- **Trigger to first word:** trig_i sampled at edge N.
  - freeze_o and busy_o go high after edge N.
  - W0 is valid after edge N+1.
- **Throughput:** with tx_ready_i held at 1, one word per cycle. The last word transfers at edge N+1+F.
  - freeze_o, busy_o and tx_valid_o drop after that edge.
  - A trig_i sampled on that same edge is treated as a drop. A new frame can start from the following edge.
- **Capture point:** counters stop on the edge after capture, so W1 equals cyc_cnt as sampled at edge N.
- **Back-pressure:** a stall of any length adds exactly that many cycles. No word is lost or duplicated.

## Test plan
- **Basic frame:** reset, start_i=1, 10 running cycles with stall_i pulsed 3 times and flush_i once, pc_i=0x28, trig_i pulse.
  - Required: 44 words, W0=0xA5000000, W1=10, W2=0x28, W3=0x00030001.
  - tx_last_o set only on W43; seq=1 afterward.
- **Register and memory content:** preload R8=7, R31=0xDEADBEEF, data-memory byte0=5.
  - Required: W12=7, W35=0xDEADBEEF, W36=5.
- **Back-pressure:** tx_ready_i toggles with a random ~50% duty.
  - Required: same 44 words in order, data stable while stalled, freeze_o held until the last transfer.
- **Overlapped trigger:** second trig_i pulse during STREAM.
  - Required: no second frame. The next triggered frame carries W0=0xA5010001.
- **Reset mid-frame:** rst low after word 20.
  - Required: all outputs at reset values asynchronously. The next frame starts with seq=0 and W1 counting from 0.
- **Saturation and wrap:** force stall_cnt to 0xFFFE and seq to 0xFFFF.
  - After 3 stall cycles: W3[31:16]=0xFFFF.
  - The header of the next frame after this one shows seq=0x0000.
